dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request acceptance to response (1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request may be accepted.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_size  input  2  0=byte, 1=half, 2=word, 3=reserved.
REQ-009 SHALL have port req_unsigned  input  1  zero-extend loads (LBU/LHU).
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data, 0 for stores/errors.
REQ-014 SHALL have port rsp_err  output  1  access fault, qualified by rsp_valid.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-016 SHALL implement FSM IDLE->BUSY->RESP->IDLE; req_ready=1 only in IDLE; BUSY skipped when LATENCY=1.
REQ-017 SHALL assert rsp_valid for exactly one cycle, exactly LATENCY cycles after the accept edge; a 4-bit down-counter tracks BUSY.
REQ-018 SHALL commit stores to the array on the accept edge and capture load data on the accept edge (loads never see a later store).
REQ-019 SHALL index the array with req_addr[log2(DEPTH)+1:2].
REQ-020 SHALL write byte lane req_addr[1:0] for byte, lanes {addr[1],0..1} for half, all lanes for word; other lanes unchanged.
REQ-021 SHALL extract loads by lane and sign-extend unless req_unsigned (ignored for word).
REQ-022 SHALL flag rsp_err, suppress the write, and return rsp_rdata=0 when req_addr[31:2] >= DEPTH or req_size==3.
REQ-023 SHALL hold request fields in registers from accept to response; port changes after accept have no effect.
REQ-024 SHALL ignore req_valid outside IDLE (no queueing); throughput is one access per LATENCY+1 cycles.

Reset
REQ-025 SHALL on rst low force state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while rst low, req_ready=1 in the first cycle after release.
REQ-026 SHALL on reset mid-operation discard the pending response; a store already committed remains.
REQ-027 SHALL NOT reset array contents; word 7 (byte address 28) SHALL initialise to 0x00000020, all others 0.

Configuration
REQ-028 SHALL with DMEM_MISALIGN_TRAP_EN defined flag rsp_err and suppress the access for half with addr[0]=1 or word with addr[1:0]!=0.
REQ-029 SHALL without DMEM_MISALIGN_TRAP_EN force misaligned addresses down to natural alignment (clear addr[0] for half, addr[1:0] for word) with no error.

Structure
REQ-030 SHALL place size encodings (SZ_B, SZ_H, SZ_W), FSM state typedef and data width constant in package dmem_pkg.
REQ-031 SHALL put lane alignment/extension in a combinational sub-module dmem_lane_fmt, instantiated once for stores and once for loads.

Verification
REQ-032 Reset then read word at byte 28, LATENCY=1 -> rsp_valid one cycle after accept, rsp_rdata=0x00000020, rsp_err=0.
REQ-033 SW 0x80FF1234 @0x40, LB @0x43, LBU @0x43, LH @0x42 -> 0xFFFFFF80, 0x00000080, 0xFFFF80FF.
REQ-034 SB 0xAB @0x41 over 0x80FF1234, LW @0x40 -> 0x80FFAB34.
REQ-035 LATENCY=3, req_valid held high -> rsp_valid 3 cycles after each accept, req_ready low 3 cycles, next accept on cycle 4.
REQ-036 LW @DEPTH*4 and size=3 -> rsp_err=1, rsp_rdata=0, memory unchanged; SH @0x41 -> err with macro, write to 0x40 without.
REQ-037 Assert rst in BUSY after SW 0x55 @0x10 -> no rsp_valid, req_ready=1 after release, LW @0x10 returns 0x00000055.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - size encodings, FSM state type and memory image for dmem_ctrl
package dmem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_R = 2'd3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // The array stores each word XORed with this image, so a zeroed array reads
  // back as the power-up contents (word 7 = 0x20) without touching it on reset.
  function automatic logic [DATA_W-1:0] init_word(input logic [29:0] widx);
    return (widx == 30'd7) ? 32'h0000_0020 : '0;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// rtl/dmem_lane_fmt.sv - byte-lane merge for stores and lane extract/extend for loads
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic              store,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] result
);

  logic [7:0]        b;
  logic [15:0]       h;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] loaded;

  always_comb begin
    b = 8'h00;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];

    merged = word;
    case (size)
      SZ_B: begin
        case (off)
          2'd0:    merged[7:0]   = data[7:0];
          2'd1:    merged[15:8]  = data[7:0];
          2'd2:    merged[23:16] = data[7:0];
          default: merged[31:24] = data[7:0];
        endcase
      end
      SZ_H: begin
        if (off[1]) merged[31:16] = data[15:0];
        else        merged[15:0]  = data[15:0];
      end
      default: merged = data;
    endcase

    loaded = '0;
    case (size)
      SZ_B:    loaded = {{24{b[7] & ~uns}}, b};
      SZ_H:    loaded = {{16{h[15] & ~uns}}, h};
      SZ_W:    loaded = word;
      default: loaded = '0;
    endcase

    result = store ? merged : loaded;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - single-port data memory controller; define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] BUSY_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic [AW-1:0]     idx;
  logic [1:0]        off;
  logic              err;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] st_word;
  logic [DATA_W-1:0] ld_word;

  assign req_ready = rst && (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[AW+1:2];
  assign cur_word  = mem[idx] ^ init_word(30'(idx));

  // Lane offset is always forced to natural alignment; the trap build only adds the fault.
  always_comb begin
    case (req_size)
      SZ_H:    off = {req_addr[1], 1'b0};
      SZ_W:    off = 2'b00;
      default: off = req_addr[1:0];
    endcase
    err = (req_addr[31:AW+2] != '0) || (req_size == SZ_R);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((req_size == SZ_H && req_addr[0]) || (req_size == SZ_W && req_addr[1:0] != 2'b00))
      err = 1'b1;
`endif
  end

  dmem_lane_fmt u_st_fmt (
    .store  (1'b1),
    .size   (req_size),
    .uns    (1'b0),
    .off    (off),
    .word   (cur_word),
    .data   (req_wdata),
    .result (st_word)
  );

  dmem_lane_fmt u_ld_fmt (
    .store  (1'b0),
    .size   (req_size),
    .uns    (req_unsigned),
    .off    (off),
    .word   (cur_word),
    .data   ({DATA_W{1'b0}}),
    .result (ld_word)
  );

  always_ff @(posedge clk) begin
    if (accept && req_we && !err)
      mem[idx] <= st_word ^ init_word(30'(idx));
  end

  // Load data and the fault flag are frozen at accept, so later port activity or stores cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rdata_q <= (req_we || err) ? '0 : ld_word;
            err_q   <= err;
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_BUSY;
              cnt   <= BUSY_LOAD;
            end
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule
